vsync_gen: RTL
==============

# vsync_gen

Vertical timing stage for the 640x480 VGA path. It sits directly downstream of the horizontal sync generator and consumes that block's free-running `xcounter`. It produces the line counter, the vertical sync pulse, the active-video enable, pixel coordinates and a start-of-frame strobe. All registered outputs share one cycle of latency from `xcounter`, so they align with the upstream registered `h_sync`.

## Interface
- `H_LAST`, 800: `xcounter` value that marks the final clock of a line (line end).
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `clk`  in  1: pixel clock, shared with the horizontal sync generator.
- `reset`  in  1: synchronous, active-high reset.
- `xcounter`  in  10: horizontal position from the upstream stage.
- `ycounter`  out  10: current line, 0 to V_TOTAL-1.
- `v_sync`  out  1: vertical sync, active-high, registered.
- `display_en`  out  1: active-video enable, registered.
- `pix_x`  out  10: registered copy of `xcounter`; valid when `display_en` is 1.
- `pix_y`  out  10: registered copy of `ycounter`; valid when `display_en` is 1.
- `frame_start`  out  1: one-cycle strobe marking the first clock of line 0.
- `frame_count`  out  8: completed-frame counter (see Configuration).

## Operation
- V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP, which is 525 by default.
- Line end condition: `xcounter == H_LAST`. No other value of `xcounter` has any effect.
  - Values above H_LAST are not treated as line end.
  - This includes 801 to 1023, which the upstream stage can produce after power-up.
- Line counter (`ycounter`):
  - On a line-end clock, `ycounter` increments.
  - When `ycounter == V_TOTAL-1` at a line-end clock, it wraps to 0 instead.
  - Otherwise it holds.
  - Counter arithmetic is 10-bit unsigned.
  - The wrap compare is exact equality. If a value ≥ V_TOTAL is ever present, the counter continues incrementing until it wraps through 1023 to 0.
- Registered outputs, each updated every clock from the current-cycle `xcounter` and `ycounter`:
  - `v_sync` is 1 when (V_ACTIVE+V_FP) ≤ `ycounter` < (V_ACTIVE+V_FP+V_SYNC), i.e. lines 490 to 491.
  - `display_en` is 1 when `xcounter` < H_ACTIVE and `ycounter` < V_ACTIVE.
  - `pix_x` takes `xcounter` and `pix_y` takes `ycounter` every clock, regardless of `display_en`.
  - `frame_start` is 1 for one cycle, on the clock after a line-end clock at which `ycounter == V_TOTAL-1`.
- `frame_count` increments, wrapping 255→0, on the same clock edge that asserts `frame_start`.
- Reset is synchronous and takes priority over every other update. On a clock with `reset` high:
  - `ycounter`, `v_sync`, `display_en`, `pix_x`, `pix_y`, `frame_start` and `frame_count` all become 0.
- Reset mid-frame: the upstream stage does not see this reset. After `reset` deasserts:
  - `ycounter` stays at 0 until the next line end.
  - The partial line at y=0 is output with `display_en` computed from live `xcounter`.
- The block has no handshake. Both sides are free-running.

## Timing
- Latency: `v_sync`, `display_en`, `pix_x`, `pix_y` and `frame_start` all lag `xcounter` by exactly 1 clock.
- `ycounter` is combinationally visible as a register output. It changes on the edge that ends a line-end clock.
- A line is H_LAST+1 clocks (801 by default). A frame is V_TOTAL × (H_LAST+1) clocks (420,525 by default).
- `v_sync` is high for V_SYNC × (H_LAST+1) consecutive clocks (1,602 by default).
- `frame_start` fires once per frame, in the same cycle that `pix_x == 0` and `pix_y == 0`.
- Simultaneous `reset` and line end: reset wins. There is no increment and no `frame_start`.

## Configuration
- Macro: `VSYNC_FRAME_COUNT_EN`.
- Defined: `frame_count` counts completed frames as specified in Operation.
- Undefined: the counter register is not built, and `frame_count` is driven constant 0. The `frame_start` strobe is unaffected.

## Test plan
- Reset release with `xcounter` stepping 0→800 repeatedly:
  - `ycounter` reaches 1 after the first `xcounter == 800` clock.
  - `ycounter` reaches 524 and then wraps to 0.
  - `frame_start` pulses exactly once per 420,525 clocks.
- Sync window: `v_sync` rises 1 clock after the line 490 start (`xcounter == 0`) and falls 1 clock after the line 492 start. It is high for exactly 1,602 clocks.
- Active region: `display_en` is 1 for exactly 640 clocks per line on lines 0 to 479, and 0 on lines 480 to 524. Total per frame is 307,200 clocks.
- Reset mid-frame at `ycounter == 300`:
  - All outputs are 0 on the next clock.
  - `ycounter` stays 0 until the next `xcounter == 800`.
  - Reset asserted together with a line end at line 524 produces no `frame_start`.
- Out-of-range input: drive `xcounter` from 1000 upward through 1023 to 0. `ycounter` must not change.
- Macro check:
  - With `VSYNC_FRAME_COUNT_EN`, `frame_count` reads 3 after 3 frames and wraps 255→0 after 256 frames.
  - Without it, `frame_count` stays 0 throughout.

Source files
------------

// File: rtl/vsync_gen.sv
// Vertical timing for the 640x480 VGA path: line counter, vsync, active enable,
// pixel coordinates and frame strobe. Define VSYNC_FRAME_COUNT_EN to build the frame counter.
module vsync_gen #(
  parameter int H_LAST   = 800,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] xcounter,
  output logic [9:0] ycounter,
  output logic       v_sync,
  output logic       display_en,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam logic [9:0] X_LAST   = 10'(H_LAST);
  localparam logic [9:0] X_ACTIVE = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACTIVE = 10'(V_ACTIVE);
  localparam logic [9:0] Y_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic line_end;
  logic frame_wrap;
  logic wrap_pending;

  assign line_end   = (xcounter == X_LAST);
  assign frame_wrap = line_end && (ycounter == Y_LAST);

  // wrap_pending marks the first clock of line 0, so frame_start lands with pix_x/pix_y == 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      ycounter     <= '0;
      v_sync       <= 1'b0;
      display_en   <= 1'b0;
      pix_x        <= '0;
      pix_y        <= '0;
      wrap_pending <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      if (frame_wrap)
        ycounter <= '0;
      else if (line_end)
        ycounter <= ycounter + 10'd1;
      v_sync       <= (ycounter >= VS_START) && (ycounter < VS_END);
      display_en   <= (xcounter < X_ACTIVE) && (ycounter < Y_ACTIVE);
      pix_x        <= xcounter;
      pix_y        <= ycounter;
      wrap_pending <= frame_wrap;
      frame_start  <= wrap_pending;
    end
  end

`ifdef VSYNC_FRAME_COUNT_EN
  // Advances on the same edge that raises frame_start.
  always_ff @(posedge clk) begin
    if (reset)
      frame_count <= '0;
    else if (wrap_pending)
      frame_count <= frame_count + 8'd1;
  end
`else
  assign frame_count = '0;
`endif

endmodule
